// File: rtl/shift_rotate_sequencer_if.sv
// Request/result handshake bundle for the multi-cycle shift/rotate unit.
// The master drives requests and result acceptance; the slave is the unit itself.
interface shift_rotate_sequencer_if #(
   parameter int SIZE = 16,
   parameter int M    = 4
);
   logic            flush;
   logic            start_valid;
   logic            start_ready;
   logic [1:0]      op;
   logic [SIZE-1:0] in_a;
   logic [M-1:0]    shift;
   logic            out_valid;
   logic            out_ready;
   logic [SIZE-1:0] out;
   logic [3:0]      flags_n_z_v_c;
   logic            busy;

   modport master (
      output flush, start_valid, op, in_a, shift, out_ready,
      input  start_ready, out_valid, out, flags_n_z_v_c, busy
   );

   modport slave (
      input  flush, start_valid, op, in_a, shift, out_ready,
      output start_ready, out_valid, out, flags_n_z_v_c, busy
   );
endinterface

// File: rtl/shift_rotate_sequencer.sv
// Variable-amount shift/rotate unit: one single-bit step per clock, result and
// N/Z/V/C flags presented behind a valid/ready handshake.
module shift_rotate_sequencer #(
   parameter int SIZE = 16,
   parameter int M    = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   shift_rotate_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
   typedef enum logic [1:0] {OP_ROR, OP_ROL, OP_LSR, OP_ASR} op_e;

   state_e          state_q, state_d;
   op_e             op_q, op_d;
   logic [SIZE-1:0] data_q, data_d;
   logic [M-1:0]    cnt_q, cnt_d;
   logic [SIZE-1:0] out_q, out_d;
   logic [3:0]      flags_q, flags_d;
   logic            start_ready_q, start_ready_d;
   logic            out_valid_q, out_valid_d;
   logic            busy_q, busy_d;

   logic [SIZE-1:0] step_data;
   logic            step_c;

   function automatic logic [3:0] nzvc(input logic [SIZE-1:0] r, input logic c);
      return {r[SIZE-1], ~|r, 1'b0, c};
   endfunction

   always_comb begin
      step_data = data_q;
      step_c    = data_q[0];
      unique case (op_q)
         OP_ROR: step_data = {data_q[0], data_q[SIZE-1:1]};
         OP_ROL: begin
            step_data = {data_q[SIZE-2:0], data_q[SIZE-1]};
            step_c    = data_q[SIZE-1];
         end
         OP_LSR: step_data = {1'b0, data_q[SIZE-1:1]};
         OP_ASR: step_data = {data_q[SIZE-1], data_q[SIZE-1:1]};
      endcase
   end

   // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      flags_d = flags_q;

      unique case (state_q)
         IDLE: begin
            if (!bus.flush && bus.start_valid) begin
               data_d = bus.in_a;
               op_d   = op_e'(bus.op);
               cnt_d  = bus.shift;
               if (bus.shift == '0) begin
                  state_d = DONE;
                  out_d   = bus.in_a;
                  flags_d = nzvc(bus.in_a, 1'b0);
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (bus.flush) begin
               state_d = IDLE;
            end else begin
               data_d = step_data;
               cnt_d  = cnt_q - M'(1);
               // Outputs only move on the final step, so an abort never exposes a partial value.
               if (cnt_q == M'(1)) begin
                  state_d = DONE;
                  out_d   = step_data;
                  flags_d = nzvc(step_data, step_c);
               end
            end
         end
         DONE: begin
            if (bus.flush || bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      start_ready_d = (state_d == IDLE);
      out_valid_d   = (state_d == DONE);
      busy_d        = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         op_q          <= OP_ROR;
         data_q        <= '0;
         cnt_q         <= '0;
         out_q         <= '0;
         flags_q       <= '0;
         start_ready_q <= 1'b1;
         out_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         data_q        <= data_d;
         cnt_q         <= cnt_d;
         out_q         <= out_d;
         flags_q       <= flags_d;
         start_ready_q <= start_ready_d;
         out_valid_q   <= out_valid_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.start_ready   = start_ready_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.busy          = busy_q;
   assign bus.out           = out_q;
   assign bus.flags_n_z_v_c = flags_q;

endmodule
